// File: rtl/log_ram_pkg.sv
// Geometry shared by the log RAM and its ring-buffer controller.
package log_ram_pkg;

  localparam int AW    = 10;
  localparam int DW    = 10;
  localparam int DEPTH = 1 << AW;

  typedef logic [AW-1:0] addr_t;
  typedef logic [DW-1:0] data_t;
  typedef logic [AW:0]   cnt_t;

  // Ring pointers wrap naturally because addr_t is exactly AW bits wide.
  function automatic addr_t next_addr(input addr_t a);
    return a + addr_t'(1);
  endfunction

endpackage

// File: rtl/log_ring_ctrl_if.sv
// Capture-side stream, drain-side stream and RAM port signals of the log ring controller.
interface log_ring_ctrl_if;
  import log_ram_pkg::*;

  logic  in_valid;
  data_t in_data;
  logic  in_ready;

  logic  out_valid;
  data_t out_data;
  logic  out_ready;

  addr_t ram_waddr;
  data_t ram_wdata;
  logic  ram_wen;
  addr_t ram_raddr;
  logic  ram_rden;
  data_t ram_rdata;

  modport master (
    input  in_valid, in_data, out_ready, ram_rdata,
    output in_ready, out_valid, out_data,
           ram_waddr, ram_wdata, ram_wen, ram_raddr, ram_rden
  );

  modport slave (
    output in_valid, in_data, out_ready, ram_rdata,
    input  in_ready, out_valid, out_data,
           ram_waddr, ram_wdata, ram_wen, ram_raddr, ram_rden
  );

endinterface

// File: rtl/log_rd_buf.sv
// Two-entry output buffer fed from the RAM read port; head is presented to the drain side.
module log_rd_buf
  import log_ram_pkg::*;
(
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       push,
  input  data_t      push_data,
  input  logic       pop,
  output logic [1:0] occ,
  output data_t      head
);

  data_t slot [2];
  logic  hd;
  logic  wsel;

  // The issue logic never lets a push land on a full buffer, so the write slot is
  // simply the one after the head when one entry is held, else the head itself.
  assign wsel = hd ^ occ[0];
  assign head = slot[hd];

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      slot[0] <= '0;
      slot[1] <= '0;
      hd      <= 1'b0;
      occ     <= 2'd0;
    end else if (clear) begin
      slot[0] <= '0;
      slot[1] <= '0;
      hd      <= 1'b0;
      occ     <= 2'd0;
    end else begin
      if (push) slot[wsel] <= push_data;
      if (pop)  hd <= ~hd;
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/log_ring_ctrl.sv
// Ring-buffer controller running a dual-port log RAM as a FIFO with a registered-read
// output buffer; optionally overwrites the oldest entry instead of back-pressuring.
module log_ring_ctrl
  import log_ram_pkg::*;
#(
  parameter bit OVERWRITE = 1'b0
)
(
  input  logic                  clk_in,
  input  logic                  rst_n,
  input  logic                  clear,
  log_ring_ctrl_if.master       bus,
  output cnt_t                  count,
  output logic                  full,
  output logic                  empty,
  output logic [15:0]           drop_cnt
);

  addr_t      wptr;
  addr_t      rptr;
  logic       pend;
  logic [1:0] occ;
  data_t      head;
  logic       wr;
  logic       pop;
  logic       iss;
  logic       drop;
  logic [2:0] need;

  // A read is only issued when the buffer is sure to have room for it once the
  // read already in the RAM output stage and this cycle's pop are accounted for.
  always_comb begin
    full          = (count == cnt_t'(DEPTH));
    bus.in_ready  = !clear && (OVERWRITE || !full);
    wr            = bus.in_valid && bus.in_ready;
    bus.out_valid = (occ != 2'd0);
    bus.out_data  = head;
    pop           = bus.out_valid && bus.out_ready;
    need          = {1'b0, occ} + {2'b00, pend};
    iss           = !clear && (count != '0) && (need < (3'd2 + {2'b00, pop}));
    drop          = OVERWRITE && full && wr && !iss;
    bus.ram_wen   = wr;
    bus.ram_waddr = wptr;
    bus.ram_wdata = bus.in_data;
    bus.ram_rden  = iss;
    bus.ram_raddr = rptr;
    empty         = (count == '0) && !pend && (occ == 2'd0);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      pend     <= 1'b0;
      drop_cnt <= '0;
    end else if (clear) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      pend     <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (wr) wptr <= next_addr(wptr);
      if (iss || drop) rptr <= next_addr(rptr);
      pend <= iss;
      if (drop && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
      // An overwrite retires the oldest entry as it stores a new one, so count holds.
      case ({wr && !drop, iss})
        2'b10:   count <= count + cnt_t'(1);
        2'b01:   count <= count - cnt_t'(1);
        default: count <= count;
      endcase
    end
  end

  log_rd_buf u_buf (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .clear     (clear),
    .push      (pend),
    .push_data (bus.ram_rdata),
    .pop       (pop),
    .occ       (occ),
    .head      (head)
  );

endmodule

// File: tb/tb_log_ring_ctrl.sv
// Directed bench for log_ring_ctrl: one back-pressure instance and one overwrite
// instance, each with its own RAM model, selected by sel.
module tb_log_ring_ctrl;
  import log_ram_pkg::*;

  logic  clk_in = 1'b0;
  logic  rst_n;
  logic  sel;
  logic  in_valid;
  logic  out_ready;
  logic  clear;
  data_t in_data;
  int    total = 0;
  int    bad   = 0;
  int    cyc   = 0;

  always #5 clk_in = ~clk_in;

  log_ring_ctrl_if bp_if ();
  log_ring_ctrl_if ow_if ();

  cnt_t        bp_count, ow_count;
  logic        bp_full, ow_full, bp_empty, ow_empty;
  logic [15:0] bp_drop, ow_drop;
  logic        clear_bp, clear_ow;

  assign bp_if.in_valid  = in_valid & ~sel;
  assign bp_if.in_data   = in_data;
  assign bp_if.out_ready = out_ready & ~sel;
  assign ow_if.in_valid  = in_valid & sel;
  assign ow_if.in_data   = in_data;
  assign ow_if.out_ready = out_ready & sel;
  assign clear_bp        = clear & ~sel;
  assign clear_ow        = clear & sel;

  log_ring_ctrl #(.OVERWRITE(1'b0)) dut_bp (
    .clk_in (clk_in), .rst_n (rst_n), .clear (clear_bp), .bus (bp_if.master),
    .count (bp_count), .full (bp_full), .empty (bp_empty), .drop_cnt (bp_drop)
  );

  log_ring_ctrl #(.OVERWRITE(1'b1)) dut_ow (
    .clk_in (clk_in), .rst_n (rst_n), .clear (clear_ow), .bus (ow_if.master),
    .count (ow_count), .full (ow_full), .empty (ow_empty), .drop_cnt (ow_drop)
  );

  // Read-first dual-port RAM models with a registered read port.
  data_t bp_mem [DEPTH];
  data_t ow_mem [DEPTH];

  always @(posedge clk_in) begin
    if (bp_if.ram_wen) bp_mem[bp_if.ram_waddr] <= bp_if.ram_wdata;
    if (bp_if.ram_rden) bp_if.ram_rdata <= bp_mem[bp_if.ram_raddr];
    if (ow_if.ram_wen) ow_mem[ow_if.ram_waddr] <= ow_if.ram_wdata;
    if (ow_if.ram_rden) ow_if.ram_rdata <= ow_mem[ow_if.ram_raddr];
  end

  logic        o_in_ready, o_out_valid, o_ram_wen, o_ram_rden, o_full, o_empty;
  data_t       o_out_data;
  addr_t       o_ram_waddr, o_ram_raddr;
  cnt_t        o_count;
  logic [15:0] o_drop;

  always_comb begin
    if (sel) begin
      o_in_ready  = ow_if.in_ready;  o_out_valid = ow_if.out_valid; o_out_data = ow_if.out_data;
      o_ram_wen   = ow_if.ram_wen;   o_ram_rden  = ow_if.ram_rden;
      o_ram_waddr = ow_if.ram_waddr; o_ram_raddr = ow_if.ram_raddr;
      o_count = ow_count; o_full = ow_full; o_empty = ow_empty; o_drop = ow_drop;
    end else begin
      o_in_ready  = bp_if.in_ready;  o_out_valid = bp_if.out_valid; o_out_data = bp_if.out_data;
      o_ram_wen   = bp_if.ram_wen;   o_ram_rden  = bp_if.ram_rden;
      o_ram_waddr = bp_if.ram_waddr; o_ram_raddr = bp_if.ram_raddr;
      o_count = bp_count; o_full = bp_full; o_empty = bp_empty; o_drop = bp_drop;
    end
  end

  // Drive one cycle's inputs at the falling edge, then report the transfers due at the next rising edge.
  task automatic tick(input logic v, input data_t d, input logic r, input logic c,
                      output logic acc, output logic popd, output data_t od);
    @(negedge clk_in);
    in_valid = v; in_data = d; out_ready = r; clear = c;
    #1;
    acc  = v & o_in_ready;
    popd = o_out_valid & r;
    od   = o_out_data;
    cyc++;
  endtask

  task automatic apply_reset(input logic s);
    @(negedge clk_in);
    sel = s; in_valid = 1'b0; out_ready = 1'b0; clear = 1'b0; in_data = '0; rst_n = 1'b0;
    @(negedge clk_in);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [11:0] hs;
    logic [28:0] st;
    logic [21:0] rm;
    @(negedge clk_in);
    rst_n = 1'b0; sel = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clear = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      hs = {o_in_ready, o_out_valid, o_out_data};
      st = {o_full, o_empty, o_count, o_drop};
      rm = {o_ram_wen, o_ram_rden, o_ram_waddr, o_ram_raddr};
      total++;
      if (hs !== {1'b1, 1'b0, 10'd0}) begin bad++; $display("FAIL reset_handshake inst=%0d got=%h want=%h", k, hs, {1'b1, 1'b0, 10'd0}); end
      total++;
      if (st !== {1'b0, 1'b1, 11'd0, 16'd0}) begin bad++; $display("FAIL reset_status inst=%0d got=%h want=%h", k, st, {1'b0, 1'b1, 11'd0, 16'd0}); end
      total++;
      if (rm !== 22'd0) begin bad++; $display("FAIL reset_ram_ports inst=%0d got=%h want=0", k, rm); end
      sel = 1'b1;
      #1;
    end
    sel = 1'b0;
    @(negedge clk_in);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic acc, popd;
    data_t od;
    int sent = 0, got = 0, first_acc = -1, first_val = -1;
    apply_reset(1'b0);
    for (int c = 0; c < 12; c++) begin
      tick(sent < 3, data_t'(sent + 1), 1'b1, 1'b0, acc, popd, od);
      if (o_out_valid && first_val < 0) first_val = c;
      if (acc) begin
        if (first_acc < 0) first_acc = c;
        sent++;
      end
      if (popd) begin
        total++;
        if (od !== data_t'(got + 1)) begin bad++; $display("FAIL basic_data idx=%0d got=%h want=%h", got, od, data_t'(got + 1)); end
        got++;
      end
    end
    total++;
    if (first_acc !== 0) begin bad++; $display("FAIL basic_first_accept got=%0d want=0", first_acc); end
    total++;
    if (first_val !== 3) begin bad++; $display("FAIL basic_latency got=%0d want=3", first_val); end
    total++;
    if (got !== 3) begin bad++; $display("FAIL basic_out_count got=%0d want=3", got); end
    total++;
    if (o_empty !== 1'b1) begin bad++; $display("FAIL basic_empty got=%b want=1", o_empty); end
  endtask

  task automatic test_backpressure();
    logic acc, popd;
    data_t od;
    int sent = 0, got = 0;
    apply_reset(1'b0);
    for (int c = 0; c < 1100; c++) begin
      tick(1'b1, data_t'(sent % 1024), 1'b0, 1'b0, acc, popd, od);
      if (!acc) break;
      sent++;
    end
    total++;
    if (sent !== 1026) begin bad++; $display("FAIL bp_accepts got=%0d want=1026", sent); end
    total++;
    if (o_full !== 1'b1) begin bad++; $display("FAIL bp_full got=%b want=1", o_full); end
    total++;
    if (o_count !== cnt_t'(1024)) begin bad++; $display("FAIL bp_count got=%0d want=1024", o_count); end
    total++;
    if (o_ram_wen !== 1'b0) begin bad++; $display("FAIL bp_wen_when_full got=%b want=0", o_ram_wen); end
    for (int c = 0; c < 1200 && got < 1026; c++) begin
      tick(1'b0, '0, 1'b1, 1'b0, acc, popd, od);
      if (popd) begin
        total++;
        if (od !== data_t'(got % 1024)) begin bad++; $display("FAIL bp_drain idx=%0d got=%h want=%h", got, od, data_t'(got % 1024)); end
        got++;
      end
    end
    total++;
    if (got !== 1026) begin bad++; $display("FAIL bp_drain_count got=%0d want=1026", got); end
    repeat (3) tick(1'b0, '0, 1'b1, 1'b0, acc, popd, od);
    total++;
    if ({o_out_valid, o_empty, o_drop} !== {1'b0, 1'b1, 16'd0}) begin
      bad++; $display("FAIL bp_after_drain valid=%b empty=%b drop=%0d want 0/1/0", o_out_valid, o_empty, o_drop);
    end
  endtask

  task automatic test_overwrite();
    logic acc, popd;
    data_t od, e;
    data_t exp_q [$];
    int missed = 0, got = 0;
    apply_reset(1'b1);
    for (int i = 0; i < 1030; i++) begin
      tick(1'b1, data_t'(i % 1024), 1'b0, 1'b0, acc, popd, od);
      if (!acc) missed++;
    end
    tick(1'b0, '0, 1'b0, 1'b0, acc, popd, od);
    total++;
    if (missed !== 0) begin bad++; $display("FAIL ow_refused got=%0d want=0", missed); end
    total++;
    if (o_drop !== 16'd4) begin bad++; $display("FAIL ow_drop_cnt got=%0d want=4", o_drop); end
    total++;
    if ({o_full, o_count} !== {1'b1, cnt_t'(1024)}) begin bad++; $display("FAIL ow_full_count full=%b count=%0d want 1/1024", o_full, o_count); end
    exp_q.push_back(data_t'(0));
    exp_q.push_back(data_t'(1));
    for (int k = 6; k < 1024; k++) exp_q.push_back(data_t'(k));
    for (int k = 0; k < 6; k++) exp_q.push_back(data_t'(k));
    for (int c = 0; c < 1200 && got < 1026; c++) begin
      tick(1'b0, '0, 1'b1, 1'b0, acc, popd, od);
      if (popd) begin
        e = exp_q.pop_front();
        total++;
        if (od !== e) begin bad++; $display("FAIL ow_drain idx=%0d got=%h want=%h", got, od, e); end
        got++;
      end
    end
    total++;
    if (got !== 1026) begin bad++; $display("FAIL ow_drain_count got=%0d want=1026", got); end
  endtask

  task automatic test_back_to_back();
    logic acc, popd, v, r;
    data_t od, d, e;
    data_t exp_q [$];
    int sent = 0, got = 0, lowready = 0, gaps = 0, extra = 0;
    apply_reset(1'b0);
    for (int c = 0; c < 3100; c++) begin
      v = (sent < 3000);
      d = data_t'((sent * 7 + 3) % 1024);
      tick(v, d, 1'b1, 1'b0, acc, popd, od);
      if (v && !acc) lowready++;
      if (acc) begin exp_q.push_back(d); sent++; end
      if (got > 0 && got < 3000 && !popd) gaps++;
      if (popd) begin
        if (exp_q.size() == 0) extra++;
        else begin
          e = exp_q.pop_front();
          total++;
          if (od !== e) begin bad++; $display("FAIL b2b_data idx=%0d got=%h want=%h", got, od, e); end
        end
        got++;
      end
    end
    total++;
    if (lowready !== 0) begin bad++; $display("FAIL b2b_in_ready_low got=%0d want=0", lowready); end
    total++;
    if ({got, gaps, extra} !== {32'd3000, 32'd0, 32'd0}) begin bad++; $display("FAIL b2b_stream got=%0d gaps=%0d extra=%0d want 3000/0/0", got, gaps, extra); end
    sent = 0; got = 0; extra = 0;
    for (int c = 0; c < 10000; c++) begin
      if (sent >= 3000 && exp_q.size() == 0) break;
      v = (sent < 3000) && ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 1) == 1);
      d = data_t'((sent * 13 + 5) % 1024);
      tick(v, d, r, 1'b0, acc, popd, od);
      if (acc) begin exp_q.push_back(d); sent++; end
      if (popd) begin
        if (exp_q.size() == 0) extra++;
        else begin
          e = exp_q.pop_front();
          total++;
          if (od !== e) begin bad++; $display("FAIL rand_data idx=%0d got=%h want=%h", got, od, e); end
        end
        got++;
      end
    end
    total++;
    if ({got, extra, exp_q.size()} !== {32'd3000, 32'd0, 32'd0}) begin
      bad++; $display("FAIL rand_stream got=%0d extra=%0d left=%0d want 3000/0/0", got, extra, exp_q.size());
    end
  endtask

  task automatic test_clear();
    logic acc, popd;
    data_t od;
    int sent = 0, got = 0;
    apply_reset(1'b0);
    for (int i = 0; i < 10; i++) tick(1'b1, data_t'(16 + i), 1'b0, 1'b0, acc, popd, od);
    tick(1'b1, 10'h2AA, 1'b0, 1'b1, acc, popd, od);
    total++;
    if (o_count !== cnt_t'(8)) begin bad++; $display("FAIL clr_count_before got=%0d want=8", o_count); end
    total++;
    if ({o_in_ready, o_ram_wen, o_ram_rden} !== 3'b000) begin bad++; $display("FAIL clr_gating got=%b want=000", {o_in_ready, o_ram_wen, o_ram_rden}); end
    tick(1'b0, '0, 1'b0, 1'b0, acc, popd, od);
    total++;
    if ({o_out_valid, o_count, o_empty} !== {1'b0, cnt_t'(0), 1'b1}) begin
      bad++; $display("FAIL clr_after valid=%b count=%0d empty=%b want 0/0/1", o_out_valid, o_count, o_empty);
    end
    for (int c = 0; c < 10; c++) begin
      tick(sent < 1, 10'h155, 1'b1, 1'b0, acc, popd, od);
      if (acc) sent++;
      if (popd) begin
        total++;
        if (od !== 10'h155) begin bad++; $display("FAIL clr_next_data got=%h want=155", od); end
        got++;
      end
    end
    total++;
    if (got !== 1) begin bad++; $display("FAIL clr_out_count got=%0d want=1", got); end
  endtask

  task automatic test_async_reset();
    logic acc, popd;
    data_t od, e;
    int sent = 0, got = 0;
    apply_reset(1'b0);
    for (int i = 0; i < 20; i++) tick(1'b1, data_t'(i + 100), 1'b1, 1'b0, acc, popd, od);
    total++;
    if ({o_out_valid, o_ram_rden} !== 2'b11) begin bad++; $display("FAIL areset_busy got=%b want=11", {o_out_valid, o_ram_rden}); end
    @(negedge clk_in);
    in_valid = 1'b0; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({o_in_ready, o_out_valid, o_out_data, o_full, o_empty, o_count, o_drop} !== {1'b1, 1'b0, 10'd0, 1'b0, 1'b1, 11'd0, 16'd0}) begin
      bad++; $display("FAIL areset_values rdy=%b val=%b data=%h full=%b empty=%b count=%0d drop=%0d",
                      o_in_ready, o_out_valid, o_out_data, o_full, o_empty, o_count, o_drop);
    end
    total++;
    if ({o_ram_wen, o_ram_rden, o_ram_waddr, o_ram_raddr} !== 22'd0) begin bad++; $display("FAIL areset_ram_ports got=%h want=0", {o_ram_wen, o_ram_rden, o_ram_waddr, o_ram_raddr}); end
    @(negedge clk_in);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick(sent < 2, (sent == 0) ? 10'h3FF : 10'h000, 1'b1, 1'b0, acc, popd, od);
      if (acc) sent++;
      if (popd) begin
        e = (got == 0) ? 10'h3FF : 10'h000;
        total++;
        if (od !== e) begin bad++; $display("FAIL areset_data idx=%0d got=%h want=%h", got, od, e); end
        got++;
      end
    end
    total++;
    if ({got, o_empty} !== {32'd2, 1'b1}) begin bad++; $display("FAIL areset_drain got=%0d empty=%b want 2/1", got, o_empty); end
  endtask

  initial begin
    sel = 1'b0; rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clear = 1'b0; in_data = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_overwrite();
    test_back_to_back();
    test_clear();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/log_ring_ctrl.md
# log_ring_ctrl

Single-clock ring-buffer controller that sequences the logging system's 10-bit-wide, 1024-deep dual-port RAM as a FIFO. Log entries arrive on a valid/ready input and are written to the RAM write port. Entries are read back through the RAM's registered read port into a 2-entry output buffer and drained on a valid/ready output. The block sits between the log capture front-end and the log drain/uplink, and both RAM ports are driven from its clock.

## Interface

- AW, 10, RAM address width; depth = 2^AW
- DW, 10, entry width
- OVERWRITE, 0, 0 = back-pressure when full; 1 = overwrite oldest entry when full
- clk_in  input  1  sole clock; RAM clk_in and clk_out both tied to it
- rst_n  input  1  asynchronous, active-low reset
- clear  input  1  synchronous flush
- in_valid  input  1  log entry offered
- in_data  input  DW  log entry
- in_ready  output  1  entry accepted when in_valid & in_ready
- out_valid  output  1  drained entry available
- out_data  output  DW  drained entry
- out_ready  input  1  sink accepts
- ram_waddr  output  AW  to RAM waddr
- ram_wdata  output  DW  to RAM wdata
- ram_wen  output  1  to RAM wen
- ram_raddr  output  AW  to RAM raddr
- ram_rden  output  1  to RAM rden
- ram_rdata  input  DW  from RAM rdata, valid the cycle after rden is sampled
- count  output  AW+1  stored entries not yet issued for read (excludes buffer and in-flight)
- full  output  1  count == 2^AW
- empty  output  1  count == 0 & no in-flight read & buffer empty
- drop_cnt  output  16  overwritten entries, saturating at 0xFFFF

## Operation

- State: wptr[AW-1:0], rptr[AW-1:0], count, pend (read in RAM output stage), buffer occupancy occ (0..2), drop_cnt.
- Write: wr = in_valid & in_ready. ram_wen = wr, ram_waddr = wptr, ram_wdata = in_data, all combinational. On wr, wptr increments modulo 2^AW.
- in_ready = !clear & (OVERWRITE | !full).
- Read issue: iss = (count != 0) & (occ - pop + pend < 2), where pop = out_valid & out_ready. ram_rden = iss, ram_raddr = rptr. On iss, rptr increments and pend is set for the next cycle.
- Capture: while pend = 1, ram_rdata is pushed into the buffer at the next edge. Overflow is impossible by construction.
- Count update: +wr −iss, except in the overwrite case below.
- Overwrite case: OVERWRITE = 1, full, wr, and !iss. rptr increments, count is unchanged, and drop_cnt increments. If iss is also true, the issued read consumes the oldest entry and no drop occurs.
- A read and a write to the same address in the same cycle cannot occur on live data, because only entries whose write completed on an earlier edge are issued.
- clear (priority over all else): next edge zeroes wptr, rptr, count, pend, occ, and drop_cnt. An in-flight ram_rdata is discarded. While clear = 1, ram_wen = 0 and ram_rden = 0.
- Output: out_valid = occ != 0; out_data = head of buffer. Push and pop in the same cycle are both honoured.

## Timing

- Reset values: all state 0. in_ready = 1, out_valid = 0, out_data = 0, full = 0, empty = 1, count = 0, drop_cnt = 0, ram_wen = 0, ram_rden = 0, addresses 0.
- Latency: entry accepted at edge t gives ram_rden high in cycle t→t+1, data captured at edge t+2, out_valid high after edge t+2. This is 2 cycles into an empty block.
- Throughput: 1 entry/cycle sustained in and out with out_ready held high.
- Back-pressure capacity: 2^AW + 2 entries (RAM + buffer).
- Reset asserted mid-operation: immediate return to reset values. Entries are lost, and RAM contents are not cleared.
- Pointer wrap from 2^AW−1 to 0 is seamless.

## Structure

- Package log_ram_pkg: AW, DW, DEPTH = 2^AW, and typedefs addr_t, data_t, cnt_t [AW:0]. The RAM and the controller share these.
- Sub-module log_rd_buf: 2-entry buffer with push/pop/occ, cleared by rst_n and clear. All pointer, count and issue logic stays in log_ring_ctrl.

## Test plan

- Reset, out_ready = 1, write 0x001, 0x002, 0x003 back-to-back -> same sequence out, first out_valid exactly 2 cycles after first accept, empty = 1 afterwards.
- OVERWRITE = 0, out_ready = 0, stream data = i mod 1024 -> in_ready falls after the 1026th accept, full = 1, count = 1024. Raise out_ready -> 0..1023, 0, 1 in order, drop_cnt = 0.
- OVERWRITE = 1, out_ready = 0, write i mod 1024 for i = 0..1029 -> drop_cnt = 4. Drain yields 0, 1, then 6..1023, 0..5.
- 3000 entries with out_ready = 1 continuously -> in_ready never low, outputs in order across 2 pointer wraps, out_ready toggled randomly with no loss or duplication.
- 10 entries stored, pulse clear for 1 cycle -> next cycle out_valid = 0, count = 0, empty = 1. Then write 0x155 -> 0x155 is the next and only output.
- rst_n pulsed low while streaming with a read in flight -> outputs equal reset values asynchronously, and post-reset writes 0x3FF, 0x000 drain correctly.
